// File: rtl/ftdl_pkg.sv
// rtl/ftdl_pkg.sv - shared widths, state encoding and sizing helper for the FTDL superblock controller
// Purpose : tile configuration widths, controller state type and a counter-width helper.
// Ports   : none (package).
package ftdl_pkg;

    // Tile configuration widths
    localparam int HW_D1           = 4;
    localparam int WBUF_ADDR_LEN   = 8;
    localparam int ACTBUF_ADDR_LEN = 5;
    localparam int PBUF_ADDR_LEN   = 4;

    // Derived widths
    localparam int ACT_ROW_LEN = ACTBUF_ADDR_LEN - 1;
    localparam int LANE_W      = (HW_D1 > 1) ? $clog2(HW_D1) : 1;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_COMP  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sblk_state_e;

    // Counter width for a 0..n-1 count; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ftdl_sblk_dly.sv
// rtl/ftdl_sblk_dly.sv - fixed-latency valid+address delay line for partial-sum writes
// Purpose : delays a push (with its address) by DEPTH cycles to line up with the MAC pipeline.
// Ports   : clk_l, rst_n      clock / async active-low reset
//           push, push_addr   entry presented this cycle
//           wr_en, wr_addr    delayed strobe; wr_addr holds the last delivered address
//           busy              an entry is still in flight ahead of the final stage
module ftdl_sblk_dly #(
    parameter int DEPTH = 4,
    parameter int AW    = 4
) (
    input  logic          clk_l,
    input  logic          rst_n,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          busy
);

    logic [DEPTH-1:0] vld_sr;
    logic [AW-1:0]    addr_sr [DEPTH];

    // Address stages only load alongside a valid, so the final stage keeps
    // the last written address while the strobe is low.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= push;
            if (push) begin
                addr_sr[0] <= push_addr;
            end
            for (int i = 1; i < DEPTH; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                if (vld_sr[i-1]) begin
                    addr_sr[i] <= addr_sr[i-1];
                end
            end
        end
    end

    assign wr_en   = vld_sr[DEPTH-1];
    assign wr_addr = addr_sr[DEPTH-1];

    // Final stage excluded: when only it is occupied, the write lands this
    // cycle and the controller may move on.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            busy = busy | vld_sr[i];
        end
    end

endmodule

// File: rtl/ftdl_sblk_ctrl.sv
// rtl/ftdl_sblk_ctrl.sv - superblock sequencer: activation load, compute address sweep, partial-sum write-back
// Purpose : free-running LOAD -> COMP -> DRAIN -> DONE loop for one FTDL tile.
// Ports   : clk_l, rst_n                      clock / async active-low reset
//           actbuf_wr_req/vld/en/addrh        activation load handshake and write port
//           wbuf_rd_addr, actbuf_rd_addrh,
//           pbuf_rd_addr                      compute-pass read addresses (0 outside COMP)
//           pbuf_wr_en, pbuf_wr_addr          delayed partial-sum write-back
//           status_sblk                       one-cycle superblock-complete pulse
module ftdl_sblk_ctrl
    import ftdl_pkg::*;
#(
    parameter int N_K      = 8,
    parameter int N_OUT    = 4,
    parameter int PIPE_LAT = 4
) (
    input  logic                     clk_l,
    input  logic                     rst_n,
    output logic [WBUF_ADDR_LEN-1:0] wbuf_rd_addr,
    output logic [HW_D1-1:0]         actbuf_wr_en,
    output logic [ACT_ROW_LEN-1:0]   actbuf_wr_addrh,
    output logic                     actbuf_wr_req,
    input  logic                     actbuf_wr_vld,
    output logic [ACT_ROW_LEN-1:0]   actbuf_rd_addrh,
    output logic                     pbuf_wr_en,
    output logic [PBUF_ADDR_LEN-1:0] pbuf_wr_addr,
    output logic [PBUF_ADDR_LEN-1:0] pbuf_rd_addr,
    output logic                     status_sblk
);

    localparam int ROW_W = cnt_w(N_K);
    localparam int OUT_W = cnt_w(N_OUT);
    localparam int LIN_W = cnt_w(N_OUT * N_K);

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(HW_D1 - 1);
    localparam logic [ROW_W-1:0]  K_LAST    = ROW_W'(N_K - 1);
    localparam logic [OUT_W-1:0]  O_LAST    = OUT_W'(N_OUT - 1);

    sblk_state_e        state;
    logic               req;
    logic [LANE_W-1:0]  lane;
    logic [ROW_W-1:0]   row;
    logic [ROW_W-1:0]   k;
    logic [OUT_W-1:0]   o;
    logic [LIN_W-1:0]   lin;

    logic                     beat;
    logic                     last_beat;
    logic                     in_comp;
    logic                     push;
    logic [PBUF_ADDR_LEN-1:0] push_addr;
    logic                     dly_busy;

    // req is only ever high in LOAD, so it alone qualifies a beat.
    assign beat      = req & actbuf_wr_vld;
    assign last_beat = beat && (row == K_LAST) && (lane == LANE_LAST);
    assign in_comp   = (state == ST_COMP);
    assign push      = in_comp && (k == K_LAST);
    assign push_addr = PBUF_ADDR_LEN'(o);

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
            req   <= 1'b0;
            lane  <= '0;
            row   <= '0;
            k     <= '0;
            o     <= '0;
            lin   <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    req <= 1'b1;
                    if (beat) begin
                        if (lane == LANE_LAST) begin
                            lane <= '0;
                            if (row == K_LAST) begin
                                row   <= '0;
                                req   <= 1'b0;
                                k     <= '0;
                                o     <= '0;
                                lin   <= '0;
                                state <= ST_COMP;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end
                end
                ST_COMP: begin
                    req <= 1'b0;
                    lin <= lin + 1'b1;
                    if (k == K_LAST) begin
                        k <= '0;
                        if (o == O_LAST) begin
                            o     <= '0;
                            lin   <= '0;
                            state <= ST_DRAIN;
                        end else begin
                            o <= o + 1'b1;
                        end
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    req <= 1'b0;
                    if (!dly_busy) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Raise req together with the return to LOAD so the loader
                    // sees it in the first LOAD cycle.
                    req   <= 1'b1;
                    lane  <= '0;
                    row   <= '0;
                    state <= ST_LOAD;
                end
                default: begin
                    req   <= 1'b0;
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    assign actbuf_wr_req   = req;
    assign actbuf_wr_en    = {HW_D1{beat}} & (HW_D1'(1) << lane);
    assign actbuf_wr_addrh = ACT_ROW_LEN'(row);

    assign wbuf_rd_addr    = in_comp ? WBUF_ADDR_LEN'(lin) : '0;
    assign actbuf_rd_addrh = in_comp ? ACT_ROW_LEN'(k)     : '0;
    assign pbuf_rd_addr    = in_comp ? PBUF_ADDR_LEN'(o)   : '0;

    assign status_sblk     = (state == ST_DONE);

    ftdl_sblk_dly #(
        .DEPTH (PIPE_LAT),
        .AW    (PBUF_ADDR_LEN)
    ) u_dly (
        .clk_l     (clk_l),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (push_addr),
        .wr_en     (pbuf_wr_en),
        .wr_addr   (pbuf_wr_addr),
        .busy      (dly_busy)
    );

endmodule

// File: tb/tb_ftdl_sblk_ctrl.sv
// tb/tb_ftdl_sblk_ctrl.sv - self-checking bench for ftdl_sblk_ctrl
module tb_ftdl_sblk_ctrl;
    import ftdl_pkg::*;

    localparam int NK  = 8;
    localparam int NO  = 4;
    localparam int LAT = 4;
    localparam int NB  = NK * HW_D1;

    logic                     clk_l = 1'b0;
    logic                     rst_n;
    logic [WBUF_ADDR_LEN-1:0] wbuf_rd_addr;
    logic [HW_D1-1:0]         actbuf_wr_en;
    logic [ACT_ROW_LEN-1:0]   actbuf_wr_addrh;
    logic                     actbuf_wr_req;
    logic                     actbuf_wr_vld;
    logic [ACT_ROW_LEN-1:0]   actbuf_rd_addrh;
    logic                     pbuf_wr_en;
    logic [PBUF_ADDR_LEN-1:0] pbuf_wr_addr;
    logic [PBUF_ADDR_LEN-1:0] pbuf_rd_addr;
    logic                     status_sblk;

    always #5 clk_l = ~clk_l;

    ftdl_sblk_ctrl #(.N_K(NK), .N_OUT(NO), .PIPE_LAT(LAT)) dut (
        .clk_l           (clk_l),
        .rst_n           (rst_n),
        .wbuf_rd_addr    (wbuf_rd_addr),
        .actbuf_wr_en    (actbuf_wr_en),
        .actbuf_wr_addrh (actbuf_wr_addrh),
        .actbuf_wr_req   (actbuf_wr_req),
        .actbuf_wr_vld   (actbuf_wr_vld),
        .actbuf_rd_addrh (actbuf_rd_addrh),
        .pbuf_wr_en      (pbuf_wr_en),
        .pbuf_wr_addr    (pbuf_wr_addr),
        .pbuf_rd_addr    (pbuf_rd_addr),
        .status_sblk     (status_sblk)
    );

    typedef struct {
        bit               vld;
        bit               req;
        logic [HW_D1-1:0] wr_en;
        int               wr_addrh;
        int               wbuf;
        int               actrd;
        int               pbrd;
        int               pbwa;
        bit               status;
    } vec_t;

    typedef struct {
        int cyc;
        int addr;
    } wr_t;

    vec_t tbl[$];
    wr_t  sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   gcyc = 0;
    int   last_pbwa = 0;
    int   comp_start = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, gcyc, got, exp);
        end
    endtask

    // Cycle-by-cycle expectation for one superblock, derived from the beat
    // count and the fixed COMP/DRAIN/DONE schedule that follows the last beat.
    task automatic build(input int idle, input int req_delay, input int mode, input bit vld_early);
        vec_t e;
        wr_t  w;
        int   beats;
        int   t;
        int   c;
        int   ci;
        bit   r;
        bit   v;
        beats = 0;
        t = 0;
        tbl.delete();
        while (beats < NB) begin
            r = (t >= req_delay);
            if (!r)              v = vld_early;
            else if (t < idle)   v = 1'b0;
            else if (mode == 0)  v = ((t - idle) < 27) || ((t - idle) >= 32);
            else if (mode == 1)  v = 1'($urandom_range(0, 1));
            else                 v = 1'b1;
            e = '{default: 0};
            e.vld      = v;
            e.req      = r;
            e.wr_addrh = beats / HW_D1;
            e.pbwa     = last_pbwa;
            if (r && v) begin
                e.wr_en = HW_D1'(1) << (beats % HW_D1);
                beats++;
            end
            tbl.push_back(e);
            t++;
        end
        c = tbl.size() - 1;
        comp_start = c + 1;
        for (int i = 0; i <= NO * NK + LAT; i++) begin
            e = '{default: 0};
            e.vld = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (i < NO * NK) begin
                e.wbuf  = i;
                e.actrd = i % NK;
                e.pbrd  = i / NK;
            end
            ci = i - (NK - 1 + LAT);
            if (ci >= 0 && (ci % NK) == 0 && ci / NK < NO) begin
                last_pbwa = ci / NK;
                w.cyc  = gcyc + comp_start + i;
                w.addr = last_pbwa;
                sb_q.push_back(w);
            end
            e.pbwa   = last_pbwa;
            e.status = (i == NO * NK + LAT);
            tbl.push_back(e);
        end
    endtask

    task automatic sb_check();
        wr_t w;
        while (sb_q.size() > 0 && sb_q[0].cyc < gcyc) begin
            w = sb_q.pop_front();
            checks++;
            errors++;
            $display("FAIL pbuf_wr_missing cyc=%0d got=none exp=addr %0d at cyc %0d", gcyc, w.addr, w.cyc);
        end
        if (pbuf_wr_en) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pbuf_wr_stray cyc=%0d got=addr %0d exp=no write", gcyc, pbuf_wr_addr);
            end else begin
                w = sb_q.pop_front();
                chk("pbuf_wr_cyc", 32'(gcyc), 32'(w.cyc));
                chk("pbuf_wr_addr_pop", 32'(pbuf_wr_addr), 32'(w.addr));
            end
        end
    endtask

    task automatic run(input int n);
        for (int idx = 0; idx < n; idx++) begin
            actbuf_wr_vld = tbl[idx].vld;
            @(negedge clk_l);
            chk("req",        32'(actbuf_wr_req),   32'(tbl[idx].req));
            chk("wr_en",      32'(actbuf_wr_en),    32'(tbl[idx].wr_en));
            chk("wr_addrh",   32'(actbuf_wr_addrh), tbl[idx].wr_addrh);
            chk("wbuf_rd",    32'(wbuf_rd_addr),    tbl[idx].wbuf);
            chk("act_rd",     32'(actbuf_rd_addrh), tbl[idx].actrd);
            chk("pbuf_rd",    32'(pbuf_rd_addr),    tbl[idx].pbrd);
            chk("pbuf_wr_addr_hold", 32'(pbuf_wr_addr), tbl[idx].pbwa);
            chk("status",     32'(status_sblk),     32'(tbl[idx].status));
            sb_check();
            @(posedge clk_l);
            #1;
            gcyc++;
        end
    endtask

    // Asserts reset mid-cycle, checks outputs clear without a clock edge,
    // then releases it just after a posedge (start of a fresh cycle 0).
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        actbuf_wr_vld = 1'b1;
        #1;
        chk("rst_req",     32'(actbuf_wr_req),   32'd0);
        chk("rst_wr_en",   32'(actbuf_wr_en),    32'd0);
        chk("rst_wbuf",    32'(wbuf_rd_addr),    32'd0);
        chk("rst_act_rd",  32'(actbuf_rd_addrh), 32'd0);
        chk("rst_pbuf_rd", 32'(pbuf_rd_addr),    32'd0);
        chk("rst_pbuf_we", 32'(pbuf_wr_en),      32'd0);
        chk("rst_status",  32'(status_sblk),     32'd0);
        sb_q.delete();
        last_pbwa = 0;
        @(posedge clk_l);
        @(posedge clk_l);
        #1;
        rst_n = 1'b1;
        gcyc += 3;
    endtask

    initial begin
        rst_n = 1'b1;
        actbuf_wr_vld = 1'b0;
        @(posedge clk_l);
        #1;
        do_reset();

        // Idle with vld low, then 27 beats / 5-cycle gap / vld tied high
        build(20, 1, 0, 1'b0);
        run(tbl.size());
        // Back-to-back superblocks: random vld, then vld tied high
        build(0, 0, 1, 1'b0);
        run(tbl.size());
        build(0, 0, 2, 1'b0);
        run(tbl.size());

        // Abort mid-COMP (first pbuf write still in flight), then full reload
        build(0, 0, 2, 1'b0);
        run(comp_start + 10);
        do_reset();
        build(0, 1, 1, 1'b1);
        run(tbl.size());

        // Abort mid-DRAIN (last pbuf write still in flight), then full reload
        build(0, 0, 2, 1'b0);
        run(comp_start + NO * NK + 2);
        do_reset();
        build(3, 1, 2, 1'b1);
        run(tbl.size());

        chk("pbuf_wr_pending", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
